// File: rtl/aplic_lat_meas_ctrl.sv
// Shared latency-measurement counter: round-robin grant to one requester, counts
// cycles from grant until that requester's stop (or timeout), then offers the result.
module aplic_lat_meas_ctrl #(
  parameter int          NUM_REQ = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF,
  localparam int         IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_sys_i,
  input  logic               clr_i,
  input  logic [NUM_REQ-1:0] req_start_i,
  input  logic [NUM_REQ-1:0] req_stop_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [IDW-1:0]     res_id_o,
  output logic [CNT_W-1:0]   res_cycles_o,
  output logic               res_timeout_o
);

  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] GRANT0    = NUM_REQ'(1);
  localparam logic [IDW-1:0]     LAST_RST  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
  logic             res_timeout_q, res_timeout_d;

  logic             start_any;
  logic             stop_hit;
  logic             at_limit;
  logic [IDW-1:0]   sel_idx;
  logic [IDW-1:0]   cand;

  assign start_any = |req_start_i;
  assign stop_hit  = req_stop_i[id_q];
  assign at_limit  = (cnt_q == TIMEOUT_C);

  // Scan from farthest to nearest so the closest requester after last_q wins.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDW'((int'(last_q) + i) % NUM_REQ);
      if (req_start_i[cand]) sel_idx = cand;
    end
  end

  always_ff @(posedge clk_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      id_q          <= '0;
      last_q        <= LAST_RST;
      res_id_q      <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      last_q        <= last_d;
      res_id_q      <= res_id_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_any) state_d = ST_RUN;
      ST_RUN:  if (stop_hit || at_limit) state_d = ST_DONE;
      ST_DONE: if (res_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) state_d = ST_IDLE;
  end

  // Stop is checked before the limit so a simultaneous stop reports no timeout.
  always_comb begin
    cnt_d         = cnt_q;
    id_d          = id_q;
    last_d        = last_q;
    res_id_d      = res_id_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_any) begin
            id_d   = sel_idx;
            last_d = sel_idx;
            cnt_d  = '0;
          end
        end
        ST_RUN: begin
          if (stop_hit) begin
            res_id_d      = id_q;
            res_cycles_d  = cnt_q;
            res_timeout_d = 1'b0;
          end else if (at_limit) begin
            res_id_d      = id_q;
            res_cycles_d  = TIMEOUT_C;
            res_timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result channel: a transfer happens on any rising edge where res_valid_o and
  // res_ready_i are both high; res_* stay stable while res_valid_o waits.
  always_comb begin
    grant_o       = '0;
    busy_o        = 1'b0;
    res_valid_o   = 1'b0;
    res_id_o      = res_id_q;
    res_cycles_o  = res_cycles_q;
    res_timeout_o = res_timeout_q;
    unique case (state_q)
      ST_RUN: begin
        grant_o = GRANT0 << id_q;
        busy_o  = 1'b1;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        res_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aplic_lat_meas_ctrl.md
APLIC_LAT_MEAS_CTRL -- requirements
Module: aplic_lat_meas_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the measurement counter; legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 32: counter and result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 32'h0000_FFFF: maximum counted value; legal range 1..2^CNT_W-1.
REQ-004 The block SHALL have port clk_i, input, 1 bit: module clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_sys_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port clr_i, input, 1 bit: synchronous abort, returns the block to IDLE.
REQ-007 The block SHALL have port req_start_i, input, NUM_REQ bits: per-requester level request for a measurement.
REQ-008 The block SHALL have port req_stop_i, input, NUM_REQ bits: per-requester stop event.
REQ-009 The block SHALL have port grant_o, output, NUM_REQ bits: one-hot owner of the counter, all-zero when not in RUN.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high in RUN or DONE.
REQ-011 The block SHALL have port res_valid_o, output, 1 bit: result available.
REQ-012 The block SHALL have port res_ready_i, input, 1 bit: result consumer ready.
REQ-013 The block SHALL have port res_id_o, output, $clog2(NUM_REQ) bits: index of the measured requester.
REQ-014 The block SHALL have port res_cycles_o, output, CNT_W bits: measured cycle count.
REQ-015 The block SHALL have port res_timeout_o, output, 1 bit: measurement ended by timeout.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE with a single internal CNT_W-bit counter.
REQ-017 In IDLE with any req_start_i bit high, the block SHALL select one requester round-robin, searching upward (wrapping) from last_grant+1.
REQ-018 On that selection the block SHALL latch the requester index into id, clear the counter to 0, update last_grant to id, and enter RUN on the next cycle.
REQ-019 In IDLE with req_start_i all zero, the block SHALL remain in IDLE with the counter held.
REQ-020 In RUN, grant_o SHALL equal one-hot(id).
REQ-021 In RUN, in a cycle where req_stop_i[id]=0 and counter<TIMEOUT, the block SHALL increment the counter by 1.
REQ-022 In RUN, in a cycle where req_stop_i[id]=1, the block SHALL capture res_cycles=counter, set res_timeout=0 and enter DONE; a stop in the first RUN cycle yields 0.
REQ-023 In RUN, in a cycle where req_stop_i[id]=0 and counter==TIMEOUT, the block SHALL capture res_cycles=TIMEOUT, set res_timeout=1 and enter DONE.
REQ-024 When stop and the timeout condition occur in the same cycle, stop SHALL win and res_timeout SHALL be 0.
REQ-025 The block SHALL ignore req_stop_i bits of non-granted requesters, and all req_start_i while in RUN or DONE.
REQ-026 The counter SHALL never wrap; its maximum value is TIMEOUT.
REQ-027 In DONE, res_valid_o SHALL be 1 and res_id_o, res_cycles_o and res_timeout_o SHALL be held stable until the handshake.
REQ-028 In DONE, a cycle with res_valid_o=1 and res_ready_i=1 SHALL complete the transfer and move the block to IDLE on the next cycle.
REQ-029 The first new grant after a transfer SHALL occur no earlier than the cycle following the return to IDLE, giving a minimum two-cycle gap between RUN phases.
REQ-030 While res_valid_o=0, res_* outputs SHALL retain their last captured values.
REQ-031 clr_i=1 in any state SHALL force IDLE, zero the counter and deassert grant_o and res_valid_o next cycle; any pending result is dropped and last_grant is kept.
REQ-032 clr_i SHALL take priority over stop, timeout and handshake in the same cycle.

Reset
REQ-033 While rst_sys_i=1, the block SHALL asynchronously force state=IDLE, counter=0, id=0 and last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-034 While rst_sys_i=1, all outputs SHALL be 0: grant_o, busy_o, res_valid_o, res_id_o, res_cycles_o and res_timeout_o.
REQ-035 Reset asserted mid-RUN or mid-DONE SHALL discard the measurement with no result produced.

Verification
REQ-036 Bench SHALL cover: start[2] pulse, stop[2] raised 5 cycles after grant -> res_id=2, res_cycles=5, res_timeout=0, grant_o=4'b0100 during RUN.
REQ-037 Bench SHALL cover: start=4'b1111 held, res_ready_i=1, stop of the granted requester in its first RUN cycle -> grants in order 0,1,2,3,0, each with res_cycles=0.
REQ-038 Bench SHALL cover: TIMEOUT=10, no stop -> DONE after counter reaches 10, res_cycles=10, res_timeout=1; with stop raised in that same cycle -> res_cycles=10, res_timeout=0.
REQ-039 Bench SHALL cover: res_ready_i held 0 for 20 cycles in DONE while other starts and stops toggle -> res_* stable, no new grant, busy_o=1.
REQ-040 Bench SHALL cover: stop of a non-granted requester during RUN -> no effect; then clr_i mid-RUN -> IDLE next cycle, grant_o=0, no res_valid_o.
REQ-041 Bench SHALL cover: rst_sys_i asserted asynchronously mid-RUN -> all outputs 0 immediately; after release with start=4'b1000 -> grant_o=4'b1000.
